pkt_buf_ctrl: RTL and testbench
===============================

# pkt_buf_ctrl

Packet-buffer controller placed between the upstream datapath and the user data path output. It owns a single-packet buffer and sequences it through three phases: capture a packet from the input bus, hand it to the pipelined processor for in-place inspection or modification, then drain it downstream. While the buffer is held by the processor or is draining, it backpressures the input bus.

## Interface
- DATA_WIDTH, 64: datapath word width.
- CTRL_WIDTH, DATA_WIDTH/8: control-word width.
- ADDR_WIDTH, 8: buffer address width; DEPTH = 2**ADDR_WIDTH words of {ctrl,data}.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  input word.
- in_ctrl  in  CTRL_WIDTH  input control.
- in_wr  in  1  input write strobe.
- in_rdy  out  1  buffer accepting input (registered).
- out_data  out  DATA_WIDTH  output word (registered).
- out_ctrl  out  CTRL_WIDTH  output control (registered).
- out_wr  out  1  output write strobe (registered).
- out_rdy  in  1  downstream can accept a word.
- proc_start  out  1  one-cycle pulse: packet ready for the processor.
- proc_done  in  1  processor releases the buffer.
- proc_addr  in  ADDR_WIDTH  processor buffer address.
- proc_we  in  1  processor write enable (data field only; ctrl preserved).
- proc_wdata  in  DATA_WIDTH  processor write data.
- proc_rdata  out  DATA_WIDTH  processor read data, 1-cycle latency.
- pkt_len  out  ADDR_WIDTH+1  captured packet length in words.
- state  out  2  FILL=00, PROC=01, DRAIN=10.

## Operation
- FILL: word accepted when in_wr && in_rdy; written at wr_ptr, wr_ptr++. Flag seen_data sets on an accepted word with in_ctrl==0. EOP = accepted word with in_ctrl!=0 && seen_data.
- On EOP: pkt_len = wr_ptr+1, -> PROC, proc_start pulses 1 cycle, in_rdy drops.
- Overflow: a non-EOP word accepted at wr_ptr==DEPTH-1 sets drop; later words are discarded until EOP, after which wr_ptr, seen_data and drop clear and the block stays in FILL. No proc_start. An EOP at address DEPTH-1 is legal (pkt_len=DEPTH).
- PROC: processor reads and writes the buffer. proc_done -> DRAIN. proc_done is ignored in FILL and DRAIN. proc_we is honoured only in PROC; a write on the same cycle as proc_done takes effect and is drained.
- DRAIN: per cycle with rd_ptr<pkt_len && out_rdy=1, emit word rd_ptr on the next cycle with out_wr=1, rd_ptr++. After the last word: -> FILL, with wr_ptr, rd_ptr and seen_data cleared and in_rdy=1 on the following cycle.

## Timing
- Reset (async assert): state=FILL, in_rdy=0, out_wr=0, out_data=0, out_ctrl=0, proc_start=0, proc_rdata=0, pkt_len=0, pointers and flags 0. Buffer contents are not cleared. in_rdy=1 on the first clk edge after deassert.
- Reset mid-packet or mid-drain: the packet is lost and the block restarts in FILL.
- EOP sampled at edge k: state=PROC and proc_start=1 after k; in_rdy=0 after k.
- proc_done sampled at edge k: state=DRAIN after k. The first out_wr can occur after k+1 (out_rdy high at k+1).
- With out_rdy held high, an N-word packet drains in N consecutive cycles. out_rdy low stalls output without losing words; out_wr is low during a stall.
- proc_rdata reflects proc_addr sampled on the previous edge.

## Configuration
- PKT_BUF_CTRL_STATS_EN defined: adds outputs pkt_count[31:0] (increments when a drain completes) and drop_count[31:0] (increments on each overflow-dropped packet). Both reset to 0 and wrap at 2**32.
- Not defined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- 1 header (ctrl=FF), 3 data, EOP (ctrl=01) written back-to-back -> pkt_len=5, proc_start pulses once, state=01, in_rdy=0.
- PROC, write proc_addr=2, data=0xDEADBEEF, then proc_done; out_rdy=1 -> 5 consecutive out_wr, word 2 data=0xDEADBEEF with ctrl unchanged, then in_rdy=1 and state=00.
- Drain with out_rdy toggling 1,0,1,0 -> each word emitted exactly once, in order, with no out_wr during low cycles.
- ADDR_WIDTH=3, 10-word packet -> no proc_start, drop_count=1 (STATS_EN), state stays 00; the next 4-word packet is captured with pkt_len=4.
- reset_n pulsed low mid-DRAIN -> all outputs 0 immediately, state=00, in_rdy=1 one edge after release.
- proc_done asserted in FILL -> ignored, state stays 00.

Source files
------------

// File: rtl/pkt_buf_ctrl.sv
// Single-packet buffer controller: capture a packet from the input bus, lend
// the buffer to the pipelined processor, then drain it downstream.
// Optional feature macro: PKT_BUF_CTRL_STATS_EN adds pkt_count and drop_count.
module pkt_buf_ctrl #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic                  proc_start,
  input  logic                  proc_done,
  input  logic [ADDR_WIDTH-1:0] proc_addr,
  input  logic                  proc_we,
  input  logic [DATA_WIDTH-1:0] proc_wdata,
  output logic [DATA_WIDTH-1:0] proc_rdata,
  output logic [ADDR_WIDTH:0]   pkt_len,
  output logic [1:0]            state
`ifdef PKT_BUF_CTRL_STATS_EN
  ,
  output logic [31:0]           pkt_count,
  output logic [31:0]           drop_count
`endif
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned MemW  = CTRL_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    StFill  = 2'b00,
    StProc  = 2'b01,
    StDrain = 2'b10
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]     pkt_len_q, pkt_len_d;
  logic                    seen_data_q, seen_data_d;
  logic                    drop_q, drop_d;
  logic                    in_rdy_q, in_rdy_d;
  logic                    proc_start_q, proc_start_d;
  logic                    out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q, out_ctrl_d;
  logic [DATA_WIDTH-1:0]   proc_rdata_q;

  logic [MemW-1:0]         mem_q [Depth];

  logic accept;
  logic is_eop;
  logic fill_we;
  logic proc_wr;
  logic pkt_done;
  logic pkt_dropped;

  assign accept  = in_wr && in_rdy_q;
  // A nonzero ctrl word only ends a packet once a data word has been seen.
  assign is_eop  = (in_ctrl != '0) && seen_data_q;
  assign proc_wr = proc_we && (state_q == StProc);

  // Next-state and registered-output logic for the three buffer phases.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    pkt_len_d    = pkt_len_q;
    seen_data_d  = seen_data_q;
    drop_d       = drop_q;
    in_rdy_d     = in_rdy_q;
    proc_start_d = 1'b0;
    out_wr_d     = 1'b0;
    out_data_d   = out_data_q;
    out_ctrl_d   = out_ctrl_q;
    fill_we      = 1'b0;
    pkt_done     = 1'b0;
    pkt_dropped  = 1'b0;

    unique case (state_q)
      StFill: begin
        in_rdy_d = 1'b1;
        if (accept) begin
          if (in_ctrl == '0) begin
            seen_data_d = 1'b1;
          end
          if (is_eop) begin
            if (drop_q) begin
              // Overflowed packet ends: discard it and wait for the next one.
              wr_ptr_d    = '0;
              seen_data_d = 1'b0;
              drop_d      = 1'b0;
              pkt_dropped = 1'b1;
            end else begin
              fill_we      = 1'b1;
              pkt_len_d    = {1'b0, wr_ptr_q} + 1'b1;
              state_d      = StProc;
              proc_start_d = 1'b1;
              in_rdy_d     = 1'b0;
            end
          end else if (!drop_q) begin
            fill_we = 1'b1;
            if (&wr_ptr_q) begin
              drop_d = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
        end
      end
      StProc: begin
        in_rdy_d = 1'b0;
        if (proc_done) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        in_rdy_d = 1'b0;
        if ((rd_ptr_q < pkt_len_q) && out_rdy) begin
          out_wr_d                 = 1'b1;
          {out_ctrl_d, out_data_d} = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
          rd_ptr_d                 = rd_ptr_q + 1'b1;
          if (rd_ptr_q == pkt_len_q - 1'b1) begin
            state_d     = StFill;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            seen_data_d = 1'b0;
            in_rdy_d    = 1'b1;
            pkt_done    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  // Control state and registered outputs; cleared asynchronously on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StFill;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pkt_len_q    <= '0;
      seen_data_q  <= 1'b0;
      drop_q       <= 1'b0;
      in_rdy_q     <= 1'b0;
      proc_start_q <= 1'b0;
      out_wr_q     <= 1'b0;
      out_data_q   <= '0;
      out_ctrl_q   <= '0;
      proc_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pkt_len_q    <= pkt_len_d;
      seen_data_q  <= seen_data_d;
      drop_q       <= drop_d;
      in_rdy_q     <= in_rdy_d;
      proc_start_q <= proc_start_d;
      out_wr_q     <= out_wr_d;
      out_data_q   <= out_data_d;
      out_ctrl_q   <= out_ctrl_d;
      proc_rdata_q <= mem_q[proc_addr][DATA_WIDTH-1:0];
    end
  end

  // Buffer storage; contents survive reset. Processor writes leave ctrl intact.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      mem_q[wr_ptr_q] <= {in_ctrl, in_data};
    end
    if (proc_wr) begin
      mem_q[proc_addr][DATA_WIDTH-1:0] <= proc_wdata;
    end
  end

`ifdef PKT_BUF_CTRL_STATS_EN
  logic [31:0] pkt_count_q;
  logic [31:0] drop_count_q;

  // Completed-drain and overflow-drop counters, wrapping naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (pkt_done) begin
        pkt_count_q <= pkt_count_q + 1'b1;
      end
      if (pkt_dropped) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
    end
  end

  assign pkt_count  = pkt_count_q;
  assign drop_count = drop_count_q;
`endif

  assign in_rdy     = in_rdy_q;
  assign out_data   = out_data_q;
  assign out_ctrl   = out_ctrl_q;
  assign out_wr     = out_wr_q;
  assign proc_start = proc_start_q;
  assign proc_rdata = proc_rdata_q;
  assign pkt_len    = pkt_len_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// Directed bench for pkt_buf_ctrl: a default-size instance and a DEPTH=8
// instance share the input stimulus so overflow can be exercised cheaply.
module tb_pkt_buf_ctrl;

  logic        clk;
  logic        reset_n;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        out_rdy;
  logic        proc_done;
  logic [7:0]  proc_addr;
  logic        proc_we;
  logic [63:0] proc_wdata;

  logic        in_rdy, out_wr, proc_start;
  logic [63:0] out_data, proc_rdata;
  logic [7:0]  out_ctrl;
  logic [8:0]  pkt_len;
  logic [1:0]  state;

  logic        s_in_rdy, s_out_wr, s_proc_start;
  logic [63:0] s_out_data, s_proc_rdata;
  logic [7:0]  s_out_ctrl;
  logic [3:0]  s_pkt_len;
  logic [1:0]  s_state;

`ifdef PKT_BUF_CTRL_STATS_EN
  logic [31:0] pkt_count, drop_count, s_pkt_count, s_drop_count;
`endif

  int checks;
  int fails;

  logic [71:0] exp_w [0:4];
  logic [71:0] exp_s [0:3];

  pkt_buf_ctrl #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_wr      (in_wr),
    .in_rdy     (in_rdy),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .out_wr     (out_wr),
    .out_rdy    (out_rdy),
    .proc_start (proc_start),
    .proc_done  (proc_done),
    .proc_addr  (proc_addr),
    .proc_we    (proc_we),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .pkt_len    (pkt_len),
    .state      (state)
`ifdef PKT_BUF_CTRL_STATS_EN
    ,
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
`endif
  );

  pkt_buf_ctrl #(.DATA_WIDTH(64), .CTRL_WIDTH(8), .ADDR_WIDTH(3)) dut_s (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .in_wr      (in_wr),
    .in_rdy     (s_in_rdy),
    .out_data   (s_out_data),
    .out_ctrl   (s_out_ctrl),
    .out_wr     (s_out_wr),
    .out_rdy    (out_rdy),
    .proc_start (s_proc_start),
    .proc_done  (proc_done),
    .proc_addr  (proc_addr[2:0]),
    .proc_we    (proc_we),
    .proc_wdata (proc_wdata),
    .proc_rdata (s_proc_rdata),
    .pkt_len    (s_pkt_len),
    .state      (s_state)
`ifdef PKT_BUF_CTRL_STATS_EN
    ,
    .pkt_count  (s_pkt_count),
    .drop_count (s_drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word for exactly one rising edge; returns at the next negedge.
  task automatic send(input logic [7:0] c, input logic [63:0] d);
    in_wr   = 1'b1;
    in_ctrl = c;
    in_data = d;
    @(negedge clk);
    in_wr   = 1'b0;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    in_data    = '0;
    in_ctrl    = '0;
    in_wr      = 1'b0;
    out_rdy    = 1'b0;
    proc_done  = 1'b0;
    proc_addr  = '0;
    proc_we    = 1'b0;
    proc_wdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 2'b00 || in_rdy !== 1'b0 || out_wr !== 1'b0 || proc_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: state=%b in_rdy=%b out_wr=%b proc_start=%b, need 00 0 0 0",
               state, in_rdy, out_wr, proc_start);
    end
    checks++;
    if (out_data !== 64'd0 || out_ctrl !== 8'd0 || proc_rdata !== 64'd0 || pkt_len !== 9'd0) begin
      fails++;
      $display("FAIL reset_data: out_data=%h out_ctrl=%h proc_rdata=%h pkt_len=%0d, need zeros",
               out_data, out_ctrl, proc_rdata, pkt_len);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || s_in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_rdy: in_rdy=%b s_in_rdy=%b, need 1 1", in_rdy, s_in_rdy);
    end
  endtask

  task automatic test_capture();
    exp_w[0] = {8'hFF, 64'h1000};
    exp_w[1] = {8'h00, 64'h1001};
    exp_w[2] = {8'h00, 64'h1002};
    exp_w[3] = {8'h00, 64'h1003};
    exp_w[4] = {8'h01, 64'h1004};
    for (int i = 0; i < 4; i++) send(exp_w[i][71:64], exp_w[i][63:0]);
    checks++;
    if (state !== 2'b00 || proc_start !== 1'b0 || in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL capture_pre_eop: state=%b proc_start=%b in_rdy=%b, need 00 0 1",
               state, proc_start, in_rdy);
    end
    send(exp_w[4][71:64], exp_w[4][63:0]);
    checks++;
    if (state !== 2'b01 || proc_start !== 1'b1 || in_rdy !== 1'b0 || pkt_len !== 9'd5) begin
      fails++;
      $display("FAIL capture_eop: state=%b proc_start=%b in_rdy=%b pkt_len=%0d, need 01 1 0 5",
               state, proc_start, in_rdy, pkt_len);
    end
    @(negedge clk);
    checks++;
    if (proc_start !== 1'b0 || state !== 2'b01) begin
      fails++;
      $display("FAIL capture_pulse: proc_start=%b state=%b, need 0 01", proc_start, state);
    end
  endtask

  task automatic test_proc_drain();
    proc_addr = 8'd1;
    @(negedge clk);
    checks++;
    if (proc_rdata !== 64'h1001) begin
      fails++;
      $display("FAIL proc_read: proc_rdata=%h, need 1001", proc_rdata);
    end
    proc_addr  = 8'd2;
    proc_we    = 1'b1;
    proc_wdata = 64'hDEADBEEF;
    @(negedge clk);
    proc_we = 1'b0;
    @(negedge clk);
    checks++;
    if (proc_rdata !== 64'hDEADBEEF) begin
      fails++;
      $display("FAIL proc_readback: proc_rdata=%h, need deadbeef", proc_rdata);
    end
    // Write on the same edge as proc_done still lands in the drained packet.
    proc_addr  = 8'd3;
    proc_we    = 1'b1;
    proc_wdata = 64'hCAFE;
    proc_done  = 1'b1;
    @(negedge clk);
    proc_we   = 1'b0;
    proc_done = 1'b0;
    out_rdy   = 1'b1;
    checks++;
    if (state !== 2'b10 || out_wr !== 1'b0) begin
      fails++;
      $display("FAIL drain_enter: state=%b out_wr=%b, need 10 0", state, out_wr);
    end
    exp_w[2] = {8'h00, 64'hDEADBEEF};
    exp_w[3] = {8'h00, 64'hCAFE};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_wr !== 1'b1 || {out_ctrl, out_data} !== exp_w[i]) begin
        fails++;
        $display("FAIL drain_word%0d: out_wr=%b word=%h, need 1 %h",
                 i, out_wr, {out_ctrl, out_data}, exp_w[i]);
      end
    end
    @(negedge clk);
    out_rdy = 1'b0;
    checks++;
    if (out_wr !== 1'b0 || state !== 2'b00 || in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL drain_end: out_wr=%b state=%b in_rdy=%b, need 0 00 1",
               out_wr, state, in_rdy);
    end
`ifdef PKT_BUF_CTRL_STATS_EN
    checks++;
    if (pkt_count !== 32'd1) begin
      fails++;
      $display("FAIL pkt_count: got %0d, need 1", pkt_count);
    end
`endif
  endtask

  task automatic test_drain_stall();
    logic [71:0] p [0:3];
    p[0] = {8'hFF, 64'h2000};
    p[1] = {8'h00, 64'h2001};
    p[2] = {8'h00, 64'h2002};
    p[3] = {8'h02, 64'h2003};
    for (int i = 0; i < 4; i++) send(p[i][71:64], p[i][63:0]);
    checks++;
    if (state !== 2'b01 || pkt_len !== 9'd4) begin
      fails++;
      $display("FAIL stall_capture: state=%b pkt_len=%0d, need 01 4", state, pkt_len);
    end
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
    for (int j = 0; j < 8; j++) begin
      out_rdy = (j % 2 == 0);
      @(negedge clk);
      checks++;
      if (j % 2 == 0) begin
        if (out_wr !== 1'b1 || {out_ctrl, out_data} !== p[j/2]) begin
          fails++;
          $display("FAIL stall_word%0d: out_wr=%b word=%h, need 1 %h",
                   j / 2, out_wr, {out_ctrl, out_data}, p[j/2]);
        end
      end else if (out_wr !== 1'b0) begin
        fails++;
        $display("FAIL stall_gap%0d: out_wr=%b, need 0", j, out_wr);
      end
    end
    out_rdy = 1'b0;
    checks++;
    if (state !== 2'b00 || in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL stall_end: state=%b in_rdy=%b, need 00 1", state, in_rdy);
    end
  endtask

  task automatic test_proc_done_fill();
    proc_done = 1'b1;
    repeat (2) @(negedge clk);
    proc_done = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'b00 || in_rdy !== 1'b1 || out_wr !== 1'b0) begin
      fails++;
      $display("FAIL done_in_fill: state=%b in_rdy=%b out_wr=%b, need 00 1 0",
               state, in_rdy, out_wr);
    end
  endtask

  task automatic test_overflow();
    logic saw_start;
    saw_start = 1'b0;
    send(8'hFF, 64'h4000);
    for (int i = 1; i < 9; i++) begin
      send(8'h00, 64'h4000 + 64'(i));
      if (s_proc_start === 1'b1) saw_start = 1'b1;
    end
    send(8'h01, 64'h4009);
    if (s_proc_start === 1'b1) saw_start = 1'b1;
    checks++;
    if (saw_start !== 1'b0 || s_state !== 2'b00 || s_in_rdy !== 1'b1) begin
      fails++;
      $display("FAIL ovf_drop: saw_start=%b s_state=%b s_in_rdy=%b, need 0 00 1",
               saw_start, s_state, s_in_rdy);
    end
    checks++;
    if (state !== 2'b01 || pkt_len !== 9'd10) begin
      fails++;
      $display("FAIL ovf_big_capture: state=%b pkt_len=%0d, need 01 10", state, pkt_len);
    end
`ifdef PKT_BUF_CTRL_STATS_EN
    checks++;
    if (s_drop_count !== 32'd1 || drop_count !== 32'd0) begin
      fails++;
      $display("FAIL drop_count: small=%0d big=%0d, need 1 0", s_drop_count, drop_count);
    end
`endif
    exp_s[0] = {8'hFF, 64'h3000};
    exp_s[1] = {8'h00, 64'h3001};
    exp_s[2] = {8'h00, 64'h3002};
    exp_s[3] = {8'h01, 64'h3003};
    for (int i = 0; i < 4; i++) send(exp_s[i][71:64], exp_s[i][63:0]);
    checks++;
    if (s_state !== 2'b01 || s_pkt_len !== 4'd4 || s_proc_start !== 1'b1) begin
      fails++;
      $display("FAIL ovf_next_pkt: s_state=%b s_pkt_len=%0d s_proc_start=%b, need 01 4 1",
               s_state, s_pkt_len, s_proc_start);
    end
  endtask

  task automatic test_reset_mid_drain();
    proc_done = 1'b1;
    @(negedge clk);
    proc_done = 1'b0;
    out_rdy   = 1'b1;
    @(negedge clk);
    checks++;
    if (out_wr !== 1'b1 || {out_ctrl, out_data} !== {8'hFF, 64'h4000} ||
        s_out_wr !== 1'b1 || {s_out_ctrl, s_out_data} !== exp_s[0]) begin
      fails++;
      $display("FAIL drain_first: big=%b/%h small=%b/%h, need 1/ff..4000 1/%h",
               out_wr, {out_ctrl, out_data}, s_out_wr, {s_out_ctrl, s_out_data}, exp_s[0]);
    end
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_wr !== 1'b0 || out_data !== 64'd0 || out_ctrl !== 8'd0 || proc_start !== 1'b0 ||
        proc_rdata !== 64'd0 || pkt_len !== 9'd0 || state !== 2'b00 || in_rdy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: wr=%b d=%h c=%h ps=%b rd=%h len=%0d st=%b rdy=%b, need zeros",
               out_wr, out_data, out_ctrl, proc_start, proc_rdata, pkt_len, state, in_rdy);
    end
    out_rdy = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_rdy !== 1'b1 || state !== 2'b00 || out_wr !== 1'b0) begin
      fails++;
      $display("FAIL reset_restart: in_rdy=%b state=%b out_wr=%b, need 1 00 0",
               in_rdy, state, out_wr);
    end
    send(8'hFF, 64'h5000);
    send(8'h00, 64'h5001);
    send(8'h03, 64'h5002);
    checks++;
    if (state !== 2'b01 || pkt_len !== 9'd3) begin
      fails++;
      $display("FAIL post_reset_pkt: state=%b pkt_len=%0d, need 01 3", state, pkt_len);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_capture();
    test_proc_drain();
    test_drain_stall();
    test_proc_done_fill();
    test_overflow();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
